// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// The pause feature is compiled in with LED_SEQ_PAUSE_EN.
package led_seq_pkg;

  typedef enum logic [1:0] {
    BLINK = 2'd0,
    SHIFT = 2'd1,
    COUNT = 2'd2
  } mode_e;

  localparam logic [7:0] BLINK_START = 8'h00;
  localparam logic [7:0] SHIFT_START = 8'h01;
  localparam logic [7:0] COUNT_START = 8'h00;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [7:0] SHIFT_LEFT_END  = 8'h80;
  localparam logic [7:0] SHIFT_RIGHT_END = 8'h01;

  function automatic mode_e next_mode(input mode_e cur);
    case (cur)
      BLINK:   next_mode = SHIFT;
      SHIFT:   next_mode = COUNT;
      default: next_mode = BLINK;
    endcase
  endfunction

  function automatic logic [7:0] start_value(input mode_e m);
    case (m)
      SHIFT:   start_value = SHIFT_START;
      COUNT:   start_value = COUNT_START;
      default: start_value = BLINK_START;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus consecutive-cycle debouncer for one raw button.
// rise is a one-cycle pulse registered together with a 0->1 change of level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic BOARD_CLK,
  input  logic BOARD_RST,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive cycles sync_2 has disagreed with level
  always_ff @(posedge BOARD_CLK) begin
    if (BOARD_RST) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      rise   <= 1'b0;
      if (sync_2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_2;
          rise  <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Mode/pattern sequencer: SW1 presses cycle BLINK/SHIFT/COUNT, TICK advances the pattern.
// Defining LED_SEQ_PAUSE_EN adds BOARD_SW2, a debounced switch that freezes the pattern.
//
// state | meaning
// BLINK | all LEDs toggle together on each tick
// SHIFT | single lit LED bounces between bit 0 and bit 7
// COUNT | LEDs show an 8-bit binary count of ticks
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       BOARD_CLK,
  input  logic       BOARD_RST,
  input  logic       TICK,
  input  logic       BOARD_SW1,
`ifdef LED_SEQ_PAUSE_EN
  input  logic       BOARD_SW2,
`endif
  output logic [7:0] BOARD_LEDS,
  output logic [1:0] MODE
);

  mode_e      mode_q, mode_d;
  logic [7:0] leds_q, leds_d;
  logic       dir_q, dir_d;
  logic       sw1_level, sw1_rise;
  logic       press;
  logic       tick_en;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
    .BOARD_CLK (BOARD_CLK),
    .BOARD_RST (BOARD_RST),
    .raw       (BOARD_SW1),
    .level     (sw1_level),
    .rise      (sw1_rise)
  );

  // rise is only ever asserted alongside a freshly accepted high level
  assign press = sw1_rise & sw1_level;

`ifdef LED_SEQ_PAUSE_EN
  logic sw2_level;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw2 (
    .BOARD_CLK (BOARD_CLK),
    .BOARD_RST (BOARD_RST),
    .raw       (BOARD_SW2),
    .level     (sw2_level),
    .rise      ()
  );

  assign tick_en = TICK & ~sw2_level;
`else
  assign tick_en = TICK;
`endif

  always_ff @(posedge BOARD_CLK) begin
    if (BOARD_RST) begin
      mode_q <= BLINK;
      leds_q <= BLINK_START;
      dir_q  <= DIR_LEFT;
    end else begin
      mode_q <= mode_d;
      leds_q <= leds_d;
      dir_q  <= dir_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    leds_d = leds_q;
    dir_d  = dir_q;
    case (mode_q)
      BLINK, SHIFT, COUNT: begin
        // a press wins over a coincident tick
        if (press) begin
          mode_d = next_mode(mode_q);
          leds_d = start_value(next_mode(mode_q));
          dir_d  = DIR_LEFT;
        end else if (tick_en) begin
          case (mode_q)
            BLINK: leds_d = ~leds_q;
            SHIFT: begin
              if (dir_q == DIR_LEFT) begin
                leds_d = {leds_q[6:0], 1'b0};
                if ({leds_q[6:0], 1'b0} == SHIFT_LEFT_END) dir_d = DIR_RIGHT;
              end else begin
                leds_d = {1'b0, leds_q[7:1]};
                if ({1'b0, leds_q[7:1]} == SHIFT_RIGHT_END) dir_d = DIR_LEFT;
              end
            end
            default: leds_d = leds_q + 8'd1;
          endcase
        end
      end
      default: begin
        mode_d = BLINK;
        leds_d = BLINK_START;
        dir_d  = DIR_LEFT;
      end
    endcase
  end

  assign BOARD_LEDS = leds_q;
  assign MODE       = mode_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer with DEBOUNCE_CYCLES=4: cycle-level model plus literal checks.
// Pause scenarios are exercised only when LED_SEQ_PAUSE_EN is defined.
module tb_led_pattern_sequencer;

  localparam int DB = 4;

  logic       BOARD_CLK = 1'b0;
  logic       BOARD_RST = 1'b1;
  logic       TICK = 1'b0;
  logic       BOARD_SW1 = 1'b0;
  logic       BOARD_SW2 = 1'b0;
  logic [7:0] BOARD_LEDS;
  logic [1:0] MODE;

  int n_pass  = 0;
  int n_total = 0;

  led_pattern_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
    .BOARD_CLK  (BOARD_CLK),
    .BOARD_RST  (BOARD_RST),
    .TICK       (TICK),
    .BOARD_SW1  (BOARD_SW1),
`ifdef LED_SEQ_PAUSE_EN
    .BOARD_SW2  (BOARD_SW2),
`endif
    .BOARD_LEDS (BOARD_LEDS),
    .MODE       (MODE)
  );

  always #5 BOARD_CLK = ~BOARD_CLK;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: modes as 0..2 arithmetic, SHIFT as a position on a 14-step bounce.
  int m_mode, m_leds, m_k, m_press;
  int s1[2], s2[2], run[2], lvl[2];
  int raw[2];
  int rise0;
  bit m_valid = 1'b0;

  always @(posedge BOARD_CLK) begin
    raw[0] = int'(BOARD_SW1);
`ifdef LED_SEQ_PAUSE_EN
    raw[1] = int'(BOARD_SW2);
`else
    raw[1] = 0;
`endif
    if (BOARD_RST) begin
      m_mode = 0; m_leds = 0; m_k = 0; m_press = 0;
      for (int b = 0; b < 2; b++) begin
        s1[b] = 0; s2[b] = 0; run[b] = 0; lvl[b] = 0;
      end
      m_valid = 1'b1;
    end else begin
      if (m_press != 0) begin
        m_mode = (m_mode + 1) % 3;
        m_k    = 0;
        m_leds = (m_mode == 1) ? 1 : 0;
      end else if (TICK && lvl[1] == 0) begin
        case (m_mode)
          0: m_leds = 255 - m_leds;
          1: begin
            m_k    = (m_k + 1) % 14;
            m_leds = 1 << ((m_k <= 7) ? m_k : 14 - m_k);
          end
          default: m_leds = (m_leds + 1) % 256;
        endcase
      end
      rise0 = 0;
      for (int b = 0; b < 2; b++) begin
        if (s2[b] != lvl[b]) begin
          run[b]++;
          if (run[b] == DB) begin
            lvl[b] = s2[b];
            run[b] = 0;
            if (b == 0 && lvl[b] == 1) rise0 = 1;
          end
        end else begin
          run[b] = 0;
        end
        s2[b] = s1[b];
        s1[b] = raw[b];
      end
      m_press = rise0;
    end
  end

  always @(posedge BOARD_CLK) begin
    #2;
    if (m_valid) begin
      check("mode_track", int'(MODE), m_mode);
      check("leds_track", int'(BOARD_LEDS), m_leds);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge BOARD_CLK);
  endtask

  task automatic pulse_tick();
    TICK = 1'b1;
    @(negedge BOARD_CLK);
    TICK = 1'b0;
  endtask

  task automatic press_sw1();
    BOARD_SW1 = 1'b1;
    cycles(10);
    BOARD_SW1 = 1'b0;
    cycles(10);
  endtask

  int exp_shift[15] = '{2, 4, 8, 16, 32, 64, 128, 64, 32, 16, 8, 4, 2, 1, 2};
  int exp_blink[3]  = '{255, 0, 255};
  int n_wait;

  initial begin
    @(negedge BOARD_CLK);
    cycles(3);
    BOARD_RST = 1'b0;
    check("reset_mode", int'(MODE), 0);
    check("reset_leds", int'(BOARD_LEDS), 0);

    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      check("blink_tick", int'(BOARD_LEDS), exp_blink[i]);
      cycles(2);
      check("blink_hold", int'(BOARD_LEDS), exp_blink[i]);
    end
    check("blink_mode", int'(MODE), 0);

    press_sw1();
    check("press_mode_shift", int'(MODE), 1);
    check("press_leds_shift", int'(BOARD_LEDS), 1);
    for (int i = 0; i < 15; i++) begin
      pulse_tick();
      check("shift_seq", int'(BOARD_LEDS), exp_shift[i]);
      cycles(1);
    end

    for (int i = 0; i < 4; i++) begin
      BOARD_SW1 = (i % 2 == 0);
      cycles(2);
    end
    check("bounce_no_press", int'(MODE), 1);
    BOARD_SW1 = 1'b1;
    n_wait = 0;
    while (MODE != 2'd2 && n_wait < 20) begin
      @(negedge BOARD_CLK);
      n_wait++;
    end
    check("press_latency", n_wait, 7);
    check("count_start", int'(BOARD_LEDS), 0);
    BOARD_SW1 = 1'b0;
    cycles(10);

    for (int i = 0; i < 255; i++) begin
      pulse_tick();
      cycles(1);
    end
    check("count_ff", int'(BOARD_LEDS), 255);
    pulse_tick();
    check("count_wrap", int'(BOARD_LEDS), 0);
    press_sw1();
    check("wrap_mode_blink", int'(MODE), 0);
    check("wrap_leds_blink", int'(BOARD_LEDS), 0);

    BOARD_SW1 = 1'b1;
    cycles(6);
    TICK = 1'b1;
    cycles(1);
    TICK = 1'b0;
    check("tick_press_mode", int'(MODE), 1);
    check("tick_press_leds", int'(BOARD_LEDS), 1);
    BOARD_SW1 = 1'b0;
    cycles(10);

    pulse_tick();
    check("shift_after_combo", int'(BOARD_LEDS), 2);
    BOARD_SW1 = 1'b1;
    cycles(4);
    BOARD_RST = 1'b1;
    cycles(1);
    BOARD_RST = 1'b0;
    check("midrst_mode", int'(MODE), 0);
    check("midrst_leds", int'(BOARD_LEDS), 0);
    cycles(2);
    BOARD_SW1 = 1'b0;
    cycles(15);
    check("midrst_no_press", int'(MODE), 0);

`ifdef LED_SEQ_PAUSE_EN
    BOARD_SW2 = 1'b1;
    cycles(8);
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      cycles(1);
    end
    check("pause_hold", int'(BOARD_LEDS), 0);
    press_sw1();
    check("pause_press_mode", int'(MODE), 1);
    check("pause_press_leds", int'(BOARD_LEDS), 1);
    BOARD_SW2 = 1'b0;
    cycles(8);
    pulse_tick();
    check("pause_resume", int'(BOARD_LEDS), 2);
`endif

    cycles(3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
